// File: rtl/vital_sign_alarm_monitor.sv
// vital_sign_alarm_monitor
//   Watches NUM_CH sensor channels sampled under a shared valid strobe.
//   Each channel debounces out-of-range samples and drives a registered
//   alarm that is either latched until acknowledged (LATCH=1) or cleared by
//   the first valid normal sample (LATCH=0). A saturating counter per
//   channel counts alarm entries.
// Ports
//   clk, rst       clock; synchronous active-high reset
//   sample_valid   all channels carry a new sample this cycle
//   sample_data    channel i at [i*SAMPLE_W +: SAMPLE_W]
//   low_thresh     per-channel lowest normal value (inclusive)
//   high_thresh    per-channel highest normal value (inclusive)
//   alarm_ack      per-channel alarm acknowledge
//   count_clr      clears every event counter
//   alarm          per-channel registered alarm
//   any_alarm      OR of alarm bits
//   event_count    channel i at [i*CNT_W +: CNT_W], saturating

module vitalSignChannel #(
  parameter int SAMPLE_W = 8,
  parameter int DEBOUNCE = 3,
  parameter int LATCH    = 1,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sampleValid,
  input  logic [SAMPLE_W-1:0] data,
  input  logic [SAMPLE_W-1:0] low,
  input  logic [SAMPLE_W-1:0] high,
  input  logic                ack,
  input  logic                countClr,
  output logic                alarm,
  output logic [CNT_W-1:0]    eventCount
);
  localparam int RUN_W = $clog2(DEBOUNCE + 1);
  localparam logic [RUN_W-1:0] DEB = RUN_W'(DEBOUNCE);

  typedef enum logic [1:0] {NORMAL, SUSPECT, ALARM} stateT;

  stateT            stateQ, stateD;
  logic [RUN_W-1:0] runQ, runD, runInc;
  logic             abnormal, normalSample, enter;

  // low > high leaves no value in range, so every valid sample is abnormal.
  assign abnormal     = sampleValid & ((data < low) | (data > high));
  assign normalSample = sampleValid & ~abnormal;
  assign runInc       = runQ + 1'b1;

  always_comb begin
    stateD = stateQ;
    runD   = runQ;
    enter  = 1'b0;
    case (stateQ)
      NORMAL: begin
        if (abnormal) begin
          runD = RUN_W'(1);
          if (DEBOUNCE == 1) begin
            stateD = ALARM;
            enter  = 1'b1;
          end else begin
            stateD = SUSPECT;
          end
        end
      end
      SUSPECT: begin
        if (abnormal) begin
          runD = runInc;
          if (runInc == DEB) begin
            stateD = ALARM;
            enter  = 1'b1;
          end
        end else if (normalSample) begin
          // Abnormal samples must be consecutive; any normal one restarts.
          stateD = NORMAL;
          runD   = '0;
        end
      end
      ALARM: begin
        // Ack wins over a same-cycle sample; that sample is discarded.
        if (ack) begin
          stateD = NORMAL;
          runD   = '0;
        end else if (LATCH == 0 && normalSample) begin
          stateD = NORMAL;
          runD   = '0;
        end
      end
      default: begin
        stateD = NORMAL;
        runD   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= NORMAL;
      runQ       <= '0;
      eventCount <= '0;
    end else begin
      stateQ <= stateD;
      runQ   <= runD;
      // Clear beats a coincident increment.
      if (countClr)
        eventCount <= '0;
      else if (enter && eventCount != {CNT_W{1'b1}})
        eventCount <= eventCount + 1'b1;
    end
  end

  assign alarm = (stateQ == ALARM);
endmodule

module vital_sign_alarm_monitor #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 8,
  parameter int DEBOUNCE = 3,
  parameter int LATCH    = 1,
  parameter int CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0] sample_data,
  input  logic [NUM_CH*SAMPLE_W-1:0] low_thresh,
  input  logic [NUM_CH*SAMPLE_W-1:0] high_thresh,
  input  logic [NUM_CH-1:0]          alarm_ack,
  input  logic                       count_clr,
  output logic [NUM_CH-1:0]          alarm,
  output logic                       any_alarm,
  output logic [NUM_CH*CNT_W-1:0]    event_count
);
  for (genvar i = 0; i < NUM_CH; i++) begin : gCh
    vitalSignChannel #(
      .SAMPLE_W(SAMPLE_W),
      .DEBOUNCE(DEBOUNCE),
      .LATCH   (LATCH),
      .CNT_W   (CNT_W)
    ) uCh (
      .clk        (clk),
      .rst        (rst),
      .sampleValid(sample_valid),
      .data       (sample_data[i*SAMPLE_W +: SAMPLE_W]),
      .low        (low_thresh[i*SAMPLE_W +: SAMPLE_W]),
      .high       (high_thresh[i*SAMPLE_W +: SAMPLE_W]),
      .ack        (alarm_ack[i]),
      .countClr   (count_clr),
      .alarm      (alarm[i]),
      .eventCount (event_count[i*CNT_W +: CNT_W])
    );
  end

  assign any_alarm = |alarm;
endmodule

// File: tb/tb_vital_sign_alarm_monitor.sv
// Directed bench: three instances share one stimulus stream.
//   dutA: defaults (LATCH=1, CNT_W=8)
//   dutB: LATCH=0
//   dutC: CNT_W=2
// Each test resets all instances and checks only the relevant one.
module tb_vital_sign_alarm_monitor;
  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic [31:0] low_thresh, high_thresh;
  logic [3:0]  alarm_ack;
  logic        count_clr;

  logic [3:0]  alarmA, alarmB, alarmC;
  logic        anyA, anyB, anyC;
  logic [31:0] evtA, evtB;
  logic [7:0]  evtC;

  int nCmp = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  vital_sign_alarm_monitor dutA (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
    .low_thresh(low_thresh), .high_thresh(high_thresh), .alarm_ack(alarm_ack),
    .count_clr(count_clr), .alarm(alarmA), .any_alarm(anyA), .event_count(evtA));

  vital_sign_alarm_monitor #(.LATCH(0)) dutB (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
    .low_thresh(low_thresh), .high_thresh(high_thresh), .alarm_ack(alarm_ack),
    .count_clr(count_clr), .alarm(alarmB), .any_alarm(anyB), .event_count(evtB));

  vital_sign_alarm_monitor #(.CNT_W(2)) dutC (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
    .low_thresh(low_thresh), .high_thresh(high_thresh), .alarm_ack(alarm_ack),
    .count_clr(count_clr), .alarm(alarmC), .any_alarm(anyC), .event_count(evtC));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; outputs are then stable #1 after the edge.
  task automatic step(input logic v, input logic [31:0] d, input logic [3:0] ack,
                      input logic cc);
    sample_valid = v;
    sample_data  = d;
    alarm_ack    = ack;
    count_clr    = cc;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    alarm_ack    = 4'h0;
    count_clr    = 1'b0;
  endtask

  // Channel 0 gets x, channels 1..3 stay at a normal 50.
  function automatic logic [31:0] c0(input logic [7:0] x);
    return {8'd50, 8'd50, 8'd50, x};
  endfunction

  task automatic s0(input logic [7:0] x);
    step(1'b1, c0(x), 4'h0, 1'b0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    step(1'b1, c0(8'd150), 4'h0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample_data  = '0;
    alarm_ack    = '0;
    count_clr    = 1'b0;
    low_thresh   = {4{8'd10}};
    high_thresh  = {4{8'd100}};
    @(posedge clk); #1;
    doReset();

    // Reset state
    chk("rst_alarm", 32'(alarmA), 0);
    chk("rst_any", 32'(anyA), 0);
    chk("rst_evt", evtA, 0);

    // 1: reset mid-SUSPECT discards the run
    s0(150); s0(150);
    doReset();
    s0(150); s0(150);
    chk("t1_no_alarm", 32'(alarmA), 0);

    // 2: three abnormal samples raise alarm the cycle after the third
    doReset();
    s0(150); s0(150);
    chk("t2_pre", 32'(alarmA), 0);
    s0(150);
    chk("t2_alarm", 32'(alarmA), 32'h1);
    chk("t2_any", 32'(anyA), 1);
    chk("t2_evt", evtA, 32'h1);

    // 3: interrupted run and inclusive boundaries never alarm; 101 does
    doReset();
    s0(150); s0(150); s0(50); s0(150); s0(150);
    chk("t3_run_reset", 32'(alarmA), 0);
    s0(10); s0(10); s0(10); s0(100); s0(100); s0(100);
    chk("t3_bounds", 32'(alarmA), 0);
    s0(9); s0(9); s0(9);
    chk("t3_below", 32'(alarmA), 32'h1);
    doReset();
    s0(101); s0(101); s0(101);
    chk("t3_above", 32'(alarmA), 32'h1);

    // 4: latched alarm ignores normal samples; ack with sample clears
    doReset();
    s0(150); s0(150); s0(150);
    s0(50); s0(50);
    chk("t4_held", 32'(alarmA), 32'h1);
    step(1'b1, c0(8'd150), 4'h1, 1'b0);
    chk("t4_acked", 32'(alarmA), 0);
    s0(150); s0(150);
    chk("t4_rearm_pre", 32'(alarmA), 0);
    s0(150);
    chk("t4_rearm", 32'(alarmA), 32'h1);
    chk("t4_evt", evtA, 32'h2);

    // 5: self-clearing mode
    doReset();
    s0(5); s0(5); s0(5);
    chk("t5_alarm", 32'(alarmB), 32'h1);
    step(1'b0, c0(8'd50), 4'h0, 1'b0);
    chk("t5_hold_novalid", 32'(alarmB), 32'h1);
    s0(50);
    chk("t5_clear", 32'(alarmB), 0);
    chk("t5_evt", evtB, 32'h1);

    // 6: saturation at 3, clear during 5th entry, all channels together
    doReset();
    for (int k = 1; k <= 4; k++) begin
      for (int j = 0; j < 3; j++) step(1'b1, {4{8'd150}}, 4'h0, 1'b0);
      chk("t6_all_alarm", 32'(alarmC), 32'hF);
      chk("t6_evt", 32'(evtC), (k < 3) ? {4{2'(k)}} : 32'hFF);
      step(1'b0, {4{8'd50}}, 4'hF, 1'b0);
      chk("t6_ack", 32'(alarmC), 0);
    end
    step(1'b1, {4{8'd150}}, 4'h0, 1'b0);
    step(1'b1, {4{8'd150}}, 4'h0, 1'b0);
    step(1'b1, {4{8'd150}}, 4'h0, 1'b1);
    chk("t6_clr_alarm", 32'(alarmC), 32'hF);
    chk("t6_clr_evt", 32'(evtC), 0);
    chk("t6_any", 32'(anyC), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
